// File: rtl/voter_pkg.sv
// voter_pkg: shared constants for the four-member majority voter.
//   - Outcome bit positions and one-hot encodings (O is indexed [3:1]).
//   - Popcount thresholds for pass / tie.
//   - popcount4(): yes-vote counter for a 4-bit ballot.
package voter_pkg;

    typedef logic [3:1] outcome_t;

    // Bit positions inside the [3:1] outcome vector.
    localparam int PASS_BIT = 3;
    localparam int TIE_BIT  = 2;
    localparam int FAIL_BIT = 1;

    localparam outcome_t OUT_PASS = 3'b100;
    localparam outcome_t OUT_TIE  = 3'b010;
    localparam outcome_t OUT_FAIL = 3'b001;
    localparam outcome_t OUT_NONE = 3'b000;

    // Sized to match the 3-bit popcount so comparisons stay width-clean.
    localparam logic [2:0] PASS_MIN = 3'd3;
    localparam logic [2:0] TIE_CNT  = 3'd2;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/voter_tally_if.sv
// voter_tally_if: ballot-in / result-out bundle for voter_tally.
//   in_vld, I        : ballot from the collection logic (master drives).
//   out_vld, O       : registered result and its valid strobe (slave drives).
//   yes_cnt          : yes-vote count of the last accepted ballot.
//   pass_cnt, tie_cnt, fail_cnt : saturating outcome totals, present only
//                      when VOTER_STATS_EN is defined.
// Parameter CNT_W sets the statistics counter width.
interface voter_tally_if #(
    parameter int CNT_W = 16
);
    import voter_pkg::*;

    logic       in_vld;
    logic [3:0] I;
    logic       out_vld;
    outcome_t   O;
    logic [2:0] yes_cnt;
`ifdef VOTER_STATS_EN
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] tie_cnt;
    logic [CNT_W-1:0] fail_cnt;
`endif

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("voter_tally_if: CNT_W must be at least 1");
    end

    modport master (
        output in_vld, I,
        input  out_vld, O, yes_cnt
`ifdef VOTER_STATS_EN
        , input pass_cnt, tie_cnt, fail_cnt
`endif
    );

    modport slave (
        input  in_vld, I,
        output out_vld, O, yes_cnt
`ifdef VOTER_STATS_EN
        , output pass_cnt, tie_cnt, fail_cnt
`endif
    );

endinterface

// File: rtl/voter_classify.sv
// voter_classify: purely combinational ballot classifier.
//   ballot   [3:0] in  : one bit per member, 1 = yes.
//   popcount [2:0] out : number of yes votes (0..4).
//   outcome  [3:1] out : one-hot pass / tie / fail.
module voter_classify
    import voter_pkg::*;
(
    input  logic [3:0] ballot,
    output logic [2:0] popcount,
    output outcome_t   outcome
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        popcount = popcount4(ballot);
        outcome  = OUT_FAIL;
        if (popcount >= PASS_MIN) begin
            outcome = OUT_PASS;
        end else if (popcount == TIE_CNT) begin
            outcome = OUT_TIE;
        end
    end

endmodule

// File: rtl/voter_tally.sv
// voter_tally: registered four-member majority voter.
//   clk  : rising-edge clock.
//   rst  : asynchronous, active-high reset; forces O = none, yes_cnt = 0,
//          out_vld = 0 and clears the statistics.
//   bus  : voter_tally_if.slave -- ballot in (in_vld, I), result out
//          (out_vld, O, yes_cnt) one cycle later; O and yes_cnt hold while
//          no ballot is accepted.
// Optional: define VOTER_STATS_EN to add saturating CNT_W-bit pass/tie/fail
// totals that update on the same edge as O.
module voter_tally
    import voter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    voter_tally_if.slave  bus
);

    logic [2:0] cls_pop;
    outcome_t   cls_out;

    voter_classify u_classify (
        .ballot   (bus.I),
        .popcount (cls_pop),
        .outcome  (cls_out)
    );

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("voter_tally: CNT_W must be at least 1");
    end

    // Result registers. A ballot presented while rst is high is dropped
    // because the reset branch wins on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_vld <= 1'b0;
            bus.O       <= OUT_NONE;
            bus.yes_cnt <= 3'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            bus.out_vld <= bus.in_vld;
            if (bus.in_vld) begin
                bus.O       <= cls_out;
                bus.yes_cnt <= cls_pop;
            end
        end
    end

`ifdef VOTER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Each counter sticks at all-ones independently of the other two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.pass_cnt <= '0;
            bus.tie_cnt  <= '0;
            bus.fail_cnt <= '0;
        end else if (bus.in_vld) begin
            if (cls_out[PASS_BIT] && bus.pass_cnt != CNT_MAX) begin
                bus.pass_cnt <= bus.pass_cnt + CNT_W'(1);
            end
            if (cls_out[TIE_BIT] && bus.tie_cnt != CNT_MAX) begin
                bus.tie_cnt <= bus.tie_cnt + CNT_W'(1);
            end
            if (cls_out[FAIL_BIT] && bus.fail_cnt != CNT_MAX) begin
                bus.fail_cnt <= bus.fail_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_voter_tally.sv
// tb_voter_tally: scoreboard bench for voter_tally.
// Expected outcome/count pairs are queued when a ballot is driven and
// popped when the DUT raises out_vld. Build with VOTER_STATS_EN defined to
// exercise the saturating counters (CNT_W = 2 in that build).
`timescale 1ns/1ps
module tb_voter_tally;

`ifdef VOTER_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    typedef struct packed {
        logic [3:1] o;
        logic [2:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    voter_tally_if #(.CNT_W(CNT_W)) bus ();

    voter_tally #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t last_exp;
    int   m_pass, m_tie, m_fail;
    int   cnt_max;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference classifier written independently of the RTL helpers.
    function automatic exp_t model(input logic [3:0] b);
        exp_t e;
        int   p;
        p = b[0] + b[1] + b[2] + b[3];
        e.y = 3'(p);
        if (p >= 3)       e.o = 3'b100;
        else if (p == 2)  e.o = 3'b010;
        else              e.o = 3'b001;
        return e;
    endfunction

    task automatic model_reset();
        m_pass = 0; m_tie = 0; m_fail = 0;
        last_exp = '0;
        sb.delete();
    endtask

    task automatic check_counters();
`ifdef VOTER_STATS_EN
        check("pass_cnt", int'(bus.pass_cnt), m_pass);
        check("tie_cnt",  int'(bus.tie_cnt),  m_tie);
        check("fail_cnt", int'(bus.fail_cnt), m_fail);
`endif
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_O"},       int'(bus.O),       0);
        check({tag, "_yes_cnt"}, int'(bus.yes_cnt), 0);
        check({tag, "_out_vld"}, int'(bus.out_vld), 0);
        check_counters();
    endtask

    // Drive one cycle of stimulus at the falling edge, then check the
    // registered result just after the following rising edge.
    task automatic step(input logic v, input logic [3:0] b);
        exp_t e;
        @(negedge clk);
        bus.in_vld = v;
        bus.I      = b;
        if (v) begin
            e = model(b);
            sb.push_back(e);
            if (e.o[3] && m_pass < cnt_max) m_pass++;
            if (e.o[2] && m_tie  < cnt_max) m_tie++;
            if (e.o[1] && m_fail < cnt_max) m_fail++;
        end
        @(posedge clk);
        #1;
        check("out_vld", int'(bus.out_vld), int'(v));
        if (bus.out_vld) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_out", 1, 0);
            end else begin
                last_exp = sb.pop_front();
                check($sformatf("O[I=%b]", b),       int'(bus.O),       int'(last_exp.o));
                check($sformatf("yes_cnt[I=%b]", b), int'(bus.yes_cnt), int'(last_exp.y));
            end
        end else begin
            check("O_hold",       int'(bus.O),       int'(last_exp.o));
            check("yes_cnt_hold", int'(bus.yes_cnt), int'(last_exp.y));
        end
        check_counters();
    endtask

    initial begin
        cnt_max    = (1 << CNT_W) - 1;
        bus.in_vld = 1'b0;
        bus.I      = 4'b0000;
        model_reset();

        // Reset held across clock edges.
        repeat (2) @(posedge clk);
        #1;
        check_cleared("rst_hold");
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive sweep, one ballot per cycle.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i));
        end

        // Hold: idle cycles keep the last result.
        step(1'b1, 4'b1110);
        repeat (3) step(1'b0, 4'b0000);

        // Back-to-back alternation.
        step(1'b1, 4'b1111);
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0011);

        // Asynchronous reset mid-cycle, no clock edge in between.
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_cleared("rst_async");
        @(negedge clk);
        rst = 1'b0;

        // Five pass ballots and one tie; saturates pass_cnt when CNT_W = 2.
        step(1'b1, 4'b1111);
        step(1'b1, 4'b0111);
        step(1'b1, 4'b1011);
        step(1'b1, 4'b1101);
        step(1'b1, 4'b1110);
        step(1'b1, 4'b0101);
`ifdef VOTER_STATS_EN
        check("pass_cnt_sat", int'(bus.pass_cnt), 3);
        check("tie_cnt_one",  int'(bus.tie_cnt),  1);
        check("fail_cnt_zero", int'(bus.fail_cnt), 0);
`endif

        // Reset during a stream: the ballot seen with rst high is dropped.
        step(1'b1, 4'b0011);
        @(negedge clk);
        bus.in_vld = 1'b1;
        bus.I      = 4'b1111;
        rst        = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_cleared("rst_stream");
        @(negedge clk);
        rst        = 1'b0;
        bus.in_vld = 1'b0;
        step(1'b0, 4'b1111);
        step(1'b1, 4'b1000);

        check("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so a stuck run still terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/voter_tally.md
Name: voter_tally

Overview:
- Registered four-member majority voter: takes a 4-bit ballot (one bit per voter, 1 = yes) and classifies it as pass, tie or fail as a one-hot 3-bit outcome.
- Also reports the yes-vote count.
- Optionally keeps saturating per-outcome statistics.
- Sits behind ballot-collection logic; downstream consumers sample the outcome when the output valid is high.

Parameters:
- CNT_W, 16, width of each statistics counter (only used when VOTER_STATS_EN is defined).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- in_vld  input  1  ballot on I is valid this cycle.
- I  input  4  ballot, bit n = vote of member n (1 = yes).
- out_vld  output  1  O and yes_cnt hold a fresh result this cycle.
- O  output  3 (index 3:1)  one-hot outcome: O[3] = pass, O[2] = tie, O[1] = fail.
- yes_cnt  output  3  number of 1s in the last accepted ballot (0..4).
- pass_cnt, tie_cnt, fail_cnt  output  CNT_W each  outcome totals (only with VOTER_STATS_EN).

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Classification (combinational from I), with popcount p = number of 1s in I:
  - p >= 3 → O = 3'b100 (pass).
  - p == 2 → O = 3'b010 (tie).
  - p <= 1 → O = 3'b001 (fail).
  - Every accepted ballot yields exactly one hot bit; 16 input codes map to 5 pass, 6 tie, 5 fail.
- Latency: one cycle.
  - On a rising clk edge with in_vld = 1: O, yes_cnt and out_vld = 1 are registered.
  - With in_vld = 0: out_vld = 0; O and yes_cnt hold their last values.
- Throughput: one ballot per cycle; in_vld may be high every cycle; no backpressure.
- Reset: asserting rst immediately forces O = 3'b000 ("no decision"), yes_cnt = 0, out_vld = 0 and all counters to 0, regardless of clk. The first ballot is accepted on the first rising edge after rst deasserts.
- Reset mid-stream: a ballot presented in the same cycle rst is high is discarded.
- X/unknown handling: none required; I is assumed driven whenever in_vld = 1.

Optional Feature:
- Macro: VOTER_STATS_EN.
- Defined:
  - pass_cnt, tie_cnt and fail_cnt exist.
  - On each accepted ballot, the counter matching the outcome increments by 1.
  - Each counter saturates at 2^CNT_W − 1 and stays there; the other counters keep counting.
  - Counters update in the same edge as O, so they are consistent with the O shown.
- Not defined:
  - The three counter ports and their logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package voter_pkg holds:
  - Outcome bit-index constants (PASS_BIT = 3, TIE_BIT = 2, FAIL_BIT = 1).
  - Encodings OUT_PASS = 3'b100, OUT_TIE = 3'b010, OUT_FAIL = 3'b001, OUT_NONE = 3'b000.
  - Thresholds PASS_MIN = 3, TIE_CNT = 2.
- One sub-module, voter_classify: purely combinational; I[3:0] → popcount[2:0] plus one-hot outcome[3:1].
- The top level holds the registers and the optional counters.

Test Plan:
- Reset: hold rst = 1, pulse clk → O = 000, yes_cnt = 0, out_vld = 0. Assert rst asynchronously mid-cycle after valid output → outputs clear without a clock edge.
- Exhaustive sweep: in_vld = 1, I = 0000..1111 on consecutive cycles → one cycle later:
  - O = 001 for 0000, 0001, 0010, 0100, 1000.
  - O = 010 for 0011, 0101, 0110, 1001, 1010, 1100.
  - O = 100 for 0111, 1011, 1101, 1110, 1111.
  - yes_cnt matches the popcount in every case.
- Hold: accept I = 1110 (O = 100), then in_vld = 0 with I = 0000 for 3 cycles → out_vld = 0, O stays 100, yes_cnt stays 3.
- Back-to-back alternation: I = 1111, 0000, 0011 with in_vld = 1 each cycle → O = 100, 001, 010 on successive cycles, out_vld held at 1.
- Stats (VOTER_STATS_EN, CNT_W = 2): feed 5 pass ballots and 1 tie → pass_cnt = 3 (saturated), tie_cnt = 1, fail_cnt = 0.
- Reset during a stream: assert rst on the cycle I = 1111 is presented → that ballot is not counted and O = 000 afterwards.
